// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control, memory-read and instruction signals between the fetch unit and its neighbours.
interface fetch_unit_if;
    logic        start, load_pc, mem_req, mem_ack, instr_valid, busy, fetch_err;
    logic [7:0]  new_pc, mem_addr, address;
    logic [15:0] mem_rdata, instruction;
    modport master (
        output start, load_pc, new_pc, mem_ack, mem_rdata,
        input  mem_req, mem_addr, instruction, address, instr_valid, busy, fetch_err
    );
    modport slave (
        input  start, load_pc, new_pc, mem_ack, mem_rdata,
        output mem_req, mem_addr, instruction, address, instr_valid, busy, fetch_err
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM (IDLE/REQ/VALID) holding the PC and last instruction.
// Define FETCH_TIMEOUT_EN to abort fetches after TIMEOUT_CYCLES unacknowledged REQ cycles.
module fetch_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_e;
    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        timeout;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  state_d = bus.start ? REQ : IDLE;
            REQ: begin
                if (bus.mem_ack) begin
                    state_d = VALID;
                    instr_d = bus.mem_rdata;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            VALID: begin
                if (bus.load_pc) begin
                    state_d = IDLE;
                    pc_d    = bus.new_pc;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end
`ifdef FETCH_TIMEOUT_EN
    localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       accept_start;
    assign accept_start = (state_q == IDLE) && bus.start;
    // the ack branch of the FSM has priority, so a limit cycle with ack still completes
    assign timeout = (state_q == REQ) && (cnt_q == LIMIT);
    always_comb begin
        cnt_d = accept_start ? 4'd0 : ((state_q == REQ) && !bus.mem_ack) ? cnt_q + 4'd1 : cnt_q;
        err_d = accept_start ? 1'b0 : (timeout && !bus.mem_ack) ? 1'b1 : err_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.fetch_err = err_q;
`else
    assign timeout       = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif
    assign bus.mem_req     = state_q == REQ;
    assign bus.busy        = state_q == REQ;
    assign bus.instr_valid = state_q == VALID;
    assign bus.mem_addr    = pc_q;
    assign bus.address     = pc_q;
    assign bus.instruction = instr_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the number of REQ-state cycles without mem_ack before a fetch is aborted (used only with FETCH_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request fetch of the instruction at the current PC.
REQ-005 load_pc  input  1  commit new_pc into the PC.
REQ-006 new_pc  input  8  next PC from the branch stage.
REQ-007 mem_req  output  1  memory read request.
REQ-008 mem_addr  output  8  memory read address.
REQ-009 mem_ack  input  1  memory read data valid.
REQ-010 mem_rdata  input  16  memory read data.
REQ-011 instruction  output  16  fetched instruction, registered.
REQ-012 address  output  8  current PC; feeds the branch stage's address input.
REQ-013 instr_valid  output  1  instruction holds a completed fetch for address.
REQ-014 busy  output  1  high in REQ state.
REQ-015 fetch_err  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and VALID, 2-bit encoded.
REQ-017 IDLE: start=1 -> REQ next cycle; otherwise stay.
REQ-018 REQ: mem_req=1, mem_addr=PC; mem_ack=1 sampled at an edge -> instruction<=mem_rdata, state VALID.
REQ-019 VALID: instr_valid=1; load_pc=1 -> PC<=new_pc, instr_valid=0, state IDLE.
REQ-020 Latency: start at edge N, mem_req high after N, mem_ack at edge N+1, instr_valid high after N+1 (2 cycles minimum).
REQ-021 mem_req SHALL be held high, and mem_addr held stable, until an ack is accepted or the fetch aborts.
REQ-022 mem_ack outside REQ SHALL be ignored.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 load_pc outside VALID SHALL be ignored; PC changes only via load_pc in VALID or via reset.
REQ-025 PC SHALL take new_pc verbatim (no increment here); all 8-bit values, including 8'hFF and 8'h00, are legal.
REQ-026 instruction SHALL hold its value until the next accepted ack.
REQ-027 mem_req, busy and instr_valid SHALL be decoded from state only, never from inputs.

Reset
REQ-028 reset=1 SHALL force, immediately and independently of clk: state IDLE, PC=8'h00, instruction=16'h0000, instr_valid=0, mem_req=0, busy=0, fetch_err=0, timeout counter=0.
REQ-029 reset asserted during REQ SHALL drop mem_req without waiting for mem_ack.
REQ-030 A mem_ack arriving in the cycle reset deasserts SHALL be ignored.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL clear on REQ entry and increment each REQ cycle without mem_ack.
REQ-032 With FETCH_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL set fetch_err, return to IDLE and leave instruction and PC unchanged.
REQ-033 With FETCH_TIMEOUT_EN, an ack in the same cycle as the limit SHALL win and fetch_err SHALL stay 0.
REQ-034 With FETCH_TIMEOUT_EN, fetch_err SHALL clear on the next accepted start.
REQ-035 Without FETCH_TIMEOUT_EN, REQ SHALL wait indefinitely, fetch_err SHALL be tied 0 and no counter SHALL be built.

Verification
REQ-036 Reset then start, mem_ack the next cycle with mem_rdata=16'h2061 -> mem_addr=8'h00, instruction=16'h2061, instr_valid high 2 cycles after start.
REQ-037 mem_ack delayed 5 cycles -> mem_req and mem_addr=PC stable for all 5 cycles, then VALID.
REQ-038 In VALID, load_pc=1 with new_pc=8'h3C, then start -> address=8'h3C, mem_addr=8'h3C; load_pc pulsed in IDLE -> PC unchanged.
REQ-039 new_pc=8'hFF loaded, then new_pc=8'h00 loaded -> address follows 8'hFF then 8'h00 with no carry artifacts.
REQ-040 Async reset mid-REQ -> mem_req low before the next edge, address=8'h00, instr_valid=0.
REQ-041 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> fetch_err=1 after 15 REQ cycles, state IDLE; next start clears fetch_err.
